// File: rtl/p_fetch.sv
// Instruction fetch sequencer: reads the instruction at IC, strobes it into IR, and fetches the argument into AR when C=0.
// Optional FETCH_TIMEOUT_EN adds a no-answer watchdog that parks the sequencer in ALARM.
module p_fetch #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk_sys,
    input  logic        clr_,
    input  logic        start,
    input  logic        ic_load,
    input  logic [0:15] ic_in,
    output logic [0:15] ic,
    output logic        mem_req,
    output logic [0:15] mem_addr,
    input  logic        mem_ack,
    input  logic [0:15] mem_data,
    output logic [0:15] w,
    output logic        w_ir,
    output logic        strob1,
    output logic        w_ar,
    output logic [0:15] ar,
    output logic        c0,
    output logic        busy,
    output logic        ready,
    output logic        alarm
);

    typedef enum logic [2:0] {
        S_IDLE, S_F_IR, S_L_IR, S_F_AR, S_L_AR, S_DONE, S_ALARM
    } state_t;

    state_t      state_q, state_d;
    logic [0:15] ic_q, ic_d;
    logic [0:15] ir_q, ir_d;
    logic [0:15] ar_q, ar_d;
    logic        c0_q, c0_d;
    logic        timeout;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    // Counter idles at 0 outside the fetch states, so every fetch entry starts fresh.
    always_comb begin
        wait_d = 8'd0;
        if ((state_q == S_F_IR || state_q == S_F_AR) && !mem_ack)
            wait_d = wait_q + 8'd1;
    end

    assign timeout = (wait_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_sys) begin
        if (!clr_) wait_q <= 8'd0;
        else       wait_q <= wait_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (!clr_) begin
            state_q <= S_IDLE;
            ic_q    <= 16'h0000;
            ir_q    <= 16'h0000;
            ar_q    <= 16'h0000;
            c0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            ir_q    <= ir_d;
            ar_q    <= ar_d;
            c0_q    <= c0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        ir_d    = ir_q;
        ar_d    = ar_q;
        c0_d    = c0_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A simultaneous load and start fetches from the new IC.
                if (ic_load) ic_d = ic_in;
                if (start)   state_d = S_F_IR;
            end
            S_F_IR: begin
                if (mem_ack) begin
                    ir_d    = mem_data;
                    ic_d    = ic_q + 16'd1;
                    state_d = S_L_IR;
                end else if (timeout) begin
                    state_d = S_ALARM;
                end
            end
            S_L_IR: begin
                c0_d    = (ir_q[13:15] == 3'b000);
                state_d = c0_d ? S_F_AR : S_DONE;
            end
            S_F_AR: begin
                if (mem_ack) begin
                    ar_d    = mem_data;
                    ic_d    = ic_q + 16'd1;
                    state_d = S_L_AR;
                end else if (timeout) begin
                    state_d = S_ALARM;
                end
            end
            S_L_AR:  state_d = S_DONE;
            S_ALARM: if (start) state_d = S_F_IR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == S_F_IR) || (state_q == S_F_AR);
        mem_addr = mem_req ? ic_q : 16'h0000;
        w_ir     = (state_q == S_L_IR);
        w_ar     = (state_q == S_L_AR);
        strob1   = w_ir || w_ar;
        w        = w_ir ? ir_q : (w_ar ? ar_q : 16'h0000);
        busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ALARM);
        ready    = (state_q == S_DONE);
`ifdef FETCH_TIMEOUT_EN
        alarm    = (state_q == S_ALARM);
`else
        alarm    = 1'b0;
`endif
    end

    assign ic = ic_q;
    assign ar = ar_q;
    assign c0 = c0_q;

endmodule

// File: tb/tb_p_fetch.sv
// Scoreboard bench for p_fetch: a memory responder with programmable ack delay, load pulses checked against queued expectations.
module tb_p_fetch;

    logic        clk_sys = 1'b0;
    logic        clr_ = 1'b0;
    logic        start = 1'b0;
    logic        ic_load = 1'b0;
    logic [0:15] ic_in = 16'h0000;
    logic [0:15] ic;
    logic        mem_req;
    logic [0:15] mem_addr;
    logic        mem_ack = 1'b0;
    logic [0:15] mem_data = 16'h0000;
    logic [0:15] w;
    logic        w_ir, strob1, w_ar;
    logic [0:15] ar;
    logic        c0, busy, ready, alarm;

    int checks = 0;
    int errors = 0;

    int ack_delay = 0;
    int wait_cnt = 0;
    logic no_ack = 1'b0;
    logic [15:0] mem [logic [15:0]];

    typedef struct {
        logic        is_ar;
        logic [15:0] w;
    } exp_t;
    exp_t sb[$];

    p_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk_sys(clk_sys), .clr_(clr_), .start(start), .ic_load(ic_load), .ic_in(ic_in),
        .ic(ic), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .w(w), .w_ir(w_ir), .strob1(strob1), .w_ar(w_ar), .ar(ar), .c0(c0),
        .busy(busy), .ready(ready), .alarm(alarm)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: ack on the (ack_delay+1)-th request cycle; unknown addresses return a scrambled word.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (mem_req && !no_ack && wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem.exists(mem_addr) ? mem[mem_addr] : (mem_addr ^ 16'hA5A5);
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 16'h0000;
                wait_cnt = mem_req ? wait_cnt + 1 : 0;
            end
        end
    end

    // Load pulse monitor: each IR/AR strobe must match the next queued expectation.
    always @(negedge clk_sys) begin
        if (w_ir || w_ar) begin
            if (sb.size() == 0) begin
                check("unexpected_load", {w_ir, w_ar, w}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("load_kind", {30'd0, w_ir, w_ar}, e.is_ar ? 32'd1 : 32'd2);
                check("load_w", w, e.w);
                check("load_strob1", strob1, 1);
            end
        end
    end

    task automatic push(input logic is_ar, input logic [15:0] v);
        exp_t e;
        e.is_ar = is_ar;
        e.w     = v;
        sb.push_back(e);
    endtask

    task automatic load_ic(input logic [15:0] a);
        ic_load = 1'b1;
        ic_in   = a;
        @(negedge clk_sys);
        ic_load = 1'b0;
    endtask

    // Leaves the bench at the negedge of the first cycle after the start edge (T1).
    task automatic kick(input logic ld, input logic [15:0] a);
        ic_load = ld;
        ic_in   = a;
        start   = 1'b1;
        @(negedge clk_sys);
        start   = 1'b0;
        ic_load = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 1;
        while (!ready && !alarm && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("done_seen", {31'd0, ready | alarm}, 1);
        lat = n;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, {mem_req, w_ir, w_ar, strob1, c0, busy, ready, alarm}, 0);
        check({tag, "_ic"}, ic, 0);
        check({tag, "_ar"}, ar, 0);
        check({tag, "_w"}, w, 0);
        check({tag, "_addr"}, mem_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_idle("reset");
        clr_ = 1'b1;
        @(negedge clk_sys);

        // C=1 instruction, immediate ack: minimum latency
        mem[16'h0100] = 16'h4401;
        load_ic(16'h0100);
        check("ic_loaded", ic, 16'h0100);
        push(1'b0, 16'h4401);
        kick(1'b0, 16'h0000);
        check("t1_req", {mem_req, busy}, 2'b11);
        check("t1_addr", mem_addr, 16'h0100);
        @(negedge clk_sys);
        check("t2_w_ir", {w_ir, strob1, mem_req}, 3'b110);
        @(negedge clk_sys);
        check("t3_ready", {ready, busy}, 2'b10);
        check("t3_c0", c0, 0);
        check("t3_ic", ic, 16'h0101);

        // C=0 with argument, both reads acked after 3 wait cycles
        mem[16'h0101] = 16'h4400;
        mem[16'h0102] = 16'h1234;
        ack_delay = 3;
        push(1'b0, 16'h4400);
        push(1'b1, 16'h1234);
        kick(1'b0, 16'h0000);
        wait_done(lat);
        check("c0_latency", lat, 11);
        check("c0_ar", ar, 16'h1234);
        check("c0_flag", c0, 1);
        check("c0_ic", ic, 16'h0103);

        // IC wrap: instruction at 0xFFFF, argument at 0x0000
        ack_delay = 0;
        mem[16'hFFFF] = 16'h0008;
        mem[16'h0000] = 16'hBEEF;
        load_ic(16'hFFFF);
        push(1'b0, 16'h0008);
        push(1'b1, 16'hBEEF);
        kick(1'b0, 16'h0000);
        check("wrap_addr", mem_addr, 16'hFFFF);
        wait_done(lat);
        check("wrap_latency", lat, 5);
        check("wrap_ar", ar, 16'hBEEF);
        check("wrap_ic", ic, 16'h0001);

`ifdef FETCH_TIMEOUT_EN
        // No answer: alarm after exactly 4 request cycles, IC untouched
        load_ic(16'h0300);
        no_ack = 1'b1;
        kick(1'b0, 16'h0000);
        n = 0;
        while (!alarm && n < 20) begin
            if (mem_req) n++;
            @(negedge clk_sys);
        end
        check("to_req_cycles", n, 4);
        check("to_flags", {alarm, mem_req, busy, ready}, 4'b1000);
        check("to_ic", ic, 16'h0300);
        // Retry with ack landing on the limit cycle: ack wins
        no_ack = 1'b0;
        ack_delay = 3;
        mem[16'h0300] = 16'h0001;
        push(1'b0, 16'h0001);
        kick(1'b0, 16'h0000);
        check("retry_addr", mem_addr, 16'h0300);
        wait_done(lat);
        check("retry_latency", lat, 6);
        check("retry_flags", {alarm, ready}, 2'b01);
        check("retry_ic", ic, 16'h0301);
        ack_delay = 0;
`endif

        // start + ic_load together in DONE, then reset mid argument fetch with ack pending
        mem[16'h2000] = 16'h5500;
        mem[16'h2001] = 16'h7777;
        push(1'b0, 16'h5500);
        kick(1'b1, 16'h2000);
        check("jump_addr", mem_addr, 16'h2000);
        @(negedge clk_sys);
        check("jump_w_ir", w_ir, 1);
        @(negedge clk_sys);
        check("far_req", mem_req, 1);
        check("far_addr", mem_addr, 16'h2001);
        clr_ = 1'b0;
        @(negedge clk_sys);
        clr_ = 1'b1;
        check_idle("clr");
        repeat (3) @(negedge clk_sys);
        check("post_clr_flags", {busy, ready, mem_req, w_ar}, 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_fetch.md
# p_fetch

Instruction fetch sequencer: the initiator on the W-bus/IR-load interface consumed by the P-D instruction decoder. On each `start` it reads the instruction word at IC from memory and presents it on W with `w_ir`/`strob1` to load IR. When the word's C field (bits 13..15) is zero, it also fetches the following word as the normal argument into AR. It owns the instruction counter (IC) and signals completion or memory no-answer to the control sequencer.

## Interface
- `TIMEOUT_CYCLES`, 15: cycles `mem_req` may stay unacknowledged before alarm (only with `FETCH_TIMEOUT_EN`); legal 1..255.

- `clk_sys`  in  1  system clock; all state changes on rising edge.
- `clr_`  in  1  reset; one clock, synchronous, active-low.
- `start`  in  1  request fetch of the next instruction; honoured only in IDLE or DONE.
- `ic_load`  in  1  load IC from `ic_in`; honoured only in IDLE or DONE.
- `ic_in`  in  [0:15]  new IC value (jump target).
- `ic`  out  [0:15]  instruction counter.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  [0:15]  read address; equals `ic` while `mem_req`=1.
- `mem_ack`  in  1  memory answer; `mem_data` valid in the same cycle.
- `mem_data`  in  [0:15]  read data.
- `w`  out  [0:15]  W bus; driven with the fetched word during a load cycle, 0 otherwise.
- `w_ir`  out  1  W->IR, one-cycle pulse.
- `strob1`  out  1  load strobe, one-cycle pulse, coincident with `w_ir` or `w_ar`.
- `w_ar`  out  1  W->AR, one-cycle pulse.
- `ar`  out  [0:15]  argument register.
- `c0`  out  1  last loaded instruction had C=0.
- `busy`  out  1  state is not IDLE, DONE or ALARM.
- `ready`  out  1  state is DONE.
- `alarm`  out  1  no-answer; state is ALARM.

## Operation
- States: IDLE, F_IR, L_IR, F_AR, L_AR, DONE, ALARM.
- IDLE/DONE + `start` -> F_IR.
- IDLE/DONE + `ic_load` -> IC := `ic_in`. When both are asserted, IC loads and the fetch addresses `ic_in`.
- F_IR: `mem_req`=1 with `mem_addr`=IC.
  - On `mem_ack`: latch `mem_data`, IC := IC+1 (mod 2^16; 0xFFFF wraps to 0x0000), go to L_IR.
- L_IR: `w`=latched word, `w_ir`=`strob1`=1; `c0` := (word[13:15]==0).
  - If C=0 -> F_AR, else -> DONE.
- F_AR: same handshake as F_IR. On `mem_ack`: IC := IC+1, `ar` := `mem_data`, go to L_AR.
- L_AR: `w`=argument, `w_ar`=`strob1`=1, then -> DONE.
- DONE: `ready`=1; holds until `start` or `clr_`.
- ALARM: `mem_req`=0, `alarm`=1. `start` -> F_IR retrying the same IC (IC is not advanced on timeout).
- `start`/`ic_load` while `busy`: ignored, no effect.
- `mem_ack` outside F_IR/F_AR: ignored.
- `clr_`=0 in any state, including mid-handshake: next edge gives IDLE, `mem_req` drops immediately after that edge, any pending data is discarded.

## Timing
- Reset values: state IDLE; `ic`, `ar`, `w`=0; `mem_req`, `w_ir`, `w_ar`, `strob1`, `c0`, `busy`, `ready`, `alarm`=0.
- All outputs are registered or decoded from state only; no combinational path from `mem_ack`/`mem_data` to any output.
- `mem_req` rises on the edge after `start` and stays high, with the address stable, through the cycle in which `mem_ack` is sampled high. It falls on the next edge.
- Minimum latency, ack in the first request cycle:
  - start@T0; req T1; load pulse T2.
  - C≠0: `ready` at T3.
  - C=0: req T3, load pulse T4, `ready` at T5.
- Each extra wait cycle without ack adds one cycle.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A wait counter clears on entry to F_IR/F_AR and increments each cycle without ack.
  - When it reaches `TIMEOUT_CYCLES` with no ack -> ALARM.
  - An ack in the same cycle the counter reaches the limit wins; no alarm.
- `FETCH_TIMEOUT_EN` undefined: no counter; the block waits indefinitely; `alarm` is tied 0 and ALARM is unreachable.

## Test plan
- Reset, IC=0x0100, ack immediate, data 0x4401 (C=1) -> `w_ir`/`strob1` pulse at T2 with w=0x4401, `c0`=0, `ready` at T3, `ic`=0x0101.
- Data 0x4400 (C=0) then argument 0x1234 with ack delayed 3 cycles -> IR pulse, then `w_ar` pulse with w=0x1234, `ar`=0x1234, `c0`=1, `ic`=+2.
- IC=0xFFFF, C=0 instruction -> instruction read at 0xFFFF, argument read at 0x0000, final `ic`=0x0001.
- Macro on, TIMEOUT_CYCLES=4, no ack -> `alarm`=1 after 4 request cycles, `mem_req`=0, `ic` unchanged. Then `start` with ack -> normal load, `alarm`=0.
- `start` and `ic_load`=0x2000 asserted together in DONE -> `mem_addr`=0x2000. Then `clr_`=0 during F_AR with ack pending -> IDLE, all outputs 0, no `w_ar` pulse.
